uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
// - Oversampling UART RX deserializer directly upstream of the main controller and RX FIFO.
// - Recovers start/data/parity/stop from serial line rx_i and pushes assembled bytes to the RX FIFO.
// - Delivers the received parity bit, frame error and overrun error for the controller's error logic.
// PARAMETERS
// - OVERSAMPLE   16  ov_tick_i pulses per bit period (power of 2, >=8)
// - SYNC_STAGES  2   flip-flop stages of the rx_i synchronizer (>=2)
// PORTS
// - clk_i            in   1  system clock, all logic on rising edge
// - rst_i            in   1  asynchronous, active-high reset
// - rx_i             in   1  serial input, idle high
// - ov_tick_i        in   1  oversample enable, 1-cycle pulse, OVERSAMPLE per bit
// - data_width_i     in   2  00=5b 01=6b 10=7b 11=8b
// - parity_mode_i    in   2  00=EVEN 01=ODD 1x=none
// - stop_bits_i      in   2  00=1 stop bit, 01=2 stop bits, 1x=1 stop bit
// - rx_fifo_full_i   in   1  RX FIFO cannot accept a push this cycle
// - data_rx_o        out  8  received word, LSB-first, unused MSBs zero
// - rx_fifo_write_o  out  1  1-cycle push strobe, data_rx_o valid same cycle
// - parity_o         out  1  received parity bit (0 when parity is off)
// - frame_error_o    out  1  stop bit sampled low; valid with rx_fifo_write_o
// - overrun_error_o  out  1  1-cycle pulse: word completed while FIFO full
// - busy_o           out  1  high from confirmed start to end of DONE
// BEHAVIOUR
// - Reset: state IDLE, counters 0, synchronizer stages 1. data_rx_o=0, parity_o=0,
//   rx_fifo_write_o=0, frame_error_o=0, overrun_error_o=0, busy_o=0. Reset mid-frame aborts at once;
//   the partial word is discarded and no push occurs.
// - rx_i passes through SYNC_STAGES flip-flops; every later reference to the line uses the synced value.
// - tick_cnt counts ov_tick_i modulo OVERSAMPLE and clears on entry to START. Sample point: tick_cnt == OVERSAMPLE/2-1.
// - The config inputs are latched on the IDLE->START transition and stay frozen until the frame ends.
// - FSM states:
//   IDLE   -> START on a synced high->low edge.
//   START  -> at the sample point, line low: DATA, busy_o=1; line high: IDLE (glitch, no output).
//   DATA   -> one bit per sample point, shifted LSB-first. After width+5 bits: PARITY if parity is on, else STOP.
//   PARITY -> store the sampled bit in parity_o, then STOP.
//   STOP   -> sample the stop bit(s); any low sample sets the frame flag. After the last stop bit: DONE.
//             With 2 stop bits, both are sampled and OR-reduced into the frame flag.
//   DONE   -> one clock. If !rx_fifo_full_i: rx_fifo_write_o=1. Otherwise: overrun_error_o=1, no push.
//             Then IDLE. The data and parity outputs hold until the next DONE.
// - Latency: the push occurs 1 clk after the sample point of the last stop bit.
// - An edge seen during STOP/DONE is not lost: the IDLE edge detector evaluates the synced line the cycle
//   after DONE, and a line still low then counts as a new start.
// - frame_error_o and the pushed data are both updated in DONE. A word with a frame error is still pushed.
// - ov_tick_i low: no state advance except the IDLE edge detect and DONE.
// CONFIGURATION
// - MAJORITY_VOTE_EN defined: samples are taken at OVERSAMPLE/2-2, -1 and 0. The bit value is the 2-of-3
//   majority, decided at OVERSAMPLE/2. All transitions move to that tick. The START glitch check uses the majority.
// - MAJORITY_VOTE_EN undefined: a single sample at OVERSAMPLE/2-1, with no extra registers.
// TESTING (ov_tick_i=1 every clk, OVERSAMPLE=16)
// - 8N1, send 0xA5 -> one rx_fifo_write_o pulse, data_rx_o=0xA5, frame=0, overrun=0,
//   push 1 clk after the stop-bit sample.
// - 5-bit EVEN parity, send 0x13 with parity bit 1 -> data_rx_o=0x13, parity_o=1; odd/even check left to the controller.
// - 8N1, 0x3C with the stop bit held low -> push with data_rx_o=0x3C, frame_error_o=1.
// - rx_i low for 4 ticks then high -> state returns to IDLE, busy_o never asserted, no push.
// - rx_fifo_full_i=1 during DONE of 0x55 -> overrun_error_o 1-cycle pulse, rx_fifo_write_o=0.
// - rst_i pulsed mid-DATA of 0xFF, then a clean 0x81 frame -> only 0x81 pushed, all outputs 0 during reset.

Source files
------------

// File: rtl/uart_receiver.sv
// Oversampling UART receive deserializer feeding the RX FIFO.
// Optional 2-of-3 majority sampling is enabled by defining MAJORITY_VOTE_EN.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       ov_tick_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] parity_mode_i,
  input  logic [1:0] stop_bits_i,
  input  logic       rx_fifo_full_i,
  output logic [7:0] data_rx_o,
  output logic       rx_fifo_write_o,
  output logic       parity_o,
  output logic       frame_error_o,
  output logic       overrun_error_o,
  output logic       busy_o
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned Half  = OVERSAMPLE / 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;

  state_e             state_q, state_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_q, par_d;
  logic               frame_q, frame_d;
  logic [1:0]         width_q, width_d;
  logic [1:0]         pmode_q, pmode_d;
  logic               two_stop_q, two_stop_d;
  logic               rx_prev_q, rx_prev_d;
  logic [7:0]         data_q, data_d;
  logic               parity_q, parity_d;
  logic               fe_q, fe_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   bit_stb;
  logic                   bit_val;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef MAJORITY_VOTE_EN
  logic [1:0] vote_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vote_q <= 2'b11;
    end else if (ov_tick_i) begin
      if (tick_q == TickW'(Half - 2)) vote_q[0] <= rx_s;
      if (tick_q == TickW'(Half - 1)) vote_q[1] <= rx_s;
    end
  end

  // Third vote is the live sample; decision lands one tick after the centre.
  assign bit_stb = ov_tick_i && (tick_q == TickW'(Half));
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
  assign bit_stb = ov_tick_i && (tick_q == TickW'(Half - 1));
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      frame_q    <= 1'b0;
      width_q    <= '0;
      pmode_q    <= '0;
      two_stop_q <= 1'b0;
      rx_prev_q  <= 1'b1;
      data_q     <= '0;
      parity_q   <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      frame_q    <= frame_d;
      width_q    <= width_d;
      pmode_q    <= pmode_d;
      two_stop_q <= two_stop_d;
      rx_prev_q  <= rx_prev_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      fe_q       <= fe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = ov_tick_i ? tick_q + TickW'(1) : tick_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frame_d    = frame_q;
    width_d    = width_q;
    pmode_d    = pmode_q;
    two_stop_d = two_stop_q;
    // Held high outside IDLE so a line still low right after DONE reads as a fresh start.
    rx_prev_d  = 1'b1;
    data_d     = data_q;
    parity_d   = parity_q;
    fe_d       = fe_q;

    unique case (state_q)
      StIdle: begin
        rx_prev_d = rx_s;
        if (rx_prev_q && !rx_s) begin
          state_d    = StStart;
          tick_d     = '0;
          width_d    = data_width_i;
          pmode_d    = parity_mode_i;
          two_stop_d = (stop_bits_i == 2'b01);
        end
      end
      StStart: begin
        if (bit_stb) begin
          if (!bit_val) begin
            state_d   = StData;
            bit_cnt_d = '0;
            shift_d   = '0;
            par_d     = 1'b0;
            frame_d   = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (bit_stb) begin
          shift_d[bit_cnt_q] = bit_val;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          // Last data bit index is width+4, i.e. {1, width}.
          if (bit_cnt_q == {1'b1, width_q}) begin
            state_d    = pmode_q[1] ? StStop : StParity;
            stop_cnt_d = 1'b0;
          end
        end
      end
      StParity: begin
        if (bit_stb) begin
          par_d   = bit_val;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_stb) begin
          frame_d = frame_q | ~bit_val;
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d  = StDone;
            data_d   = shift_q;
            parity_d = pmode_q[1] ? 1'b0 : par_q;
            fe_d     = frame_q | ~bit_val;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign data_rx_o       = data_q;
  assign parity_o        = parity_q;
  assign frame_error_o   = fe_q;
  assign rx_fifo_write_o = (state_q == StDone) && !rx_fifo_full_i;
  assign overrun_error_o = (state_q == StDone) && rx_fifo_full_i;
  assign busy_o          = (state_q == StData) || (state_q == StParity) ||
                           (state_q == StStop) || (state_q == StDone);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames plus randomized frames against a frame-level model.
module tb_uart_receiver;

  localparam int OS = 16;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ov_tick = 1'b1;
  logic [1:0] dw = 2'b11;
  logic [1:0] pm = 2'b10;
  logic [1:0] sb = 2'b00;
  logic       full = 1'b0;

  logic [7:0] data_rx;
  logic       wr, par_o, fe_o, ovr_o, busy_o;

  uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(SS)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_i           (rx),
    .ov_tick_i      (ov_tick),
    .data_width_i   (dw),
    .parity_mode_i  (pm),
    .stop_bits_i    (sb),
    .rx_fifo_full_i (full),
    .data_rx_o      (data_rx),
    .rx_fifo_write_o(wr),
    .parity_o       (par_o),
    .frame_error_o  (fe_o),
    .overrun_error_o(ovr_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every push and overrun, plus busy cycle count, sampled mid-cycle.
  logic [7:0] q_data[$];
  logic       q_par[$];
  logic       q_fe[$];
  int         q_cyc[$];
  int         ovr_cnt = 0;
  int         ovr_cyc = 0;
  int         busy_cnt = 0;

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      q_data.push_back(data_rx);
      q_par.push_back(par_o);
      q_fe.push_back(fe_o);
      q_cyc.push_back(cyc);
    end
    if (ovr_o === 1'b1) begin
      ovr_cnt <= ovr_cnt + 1;
      ovr_cyc <= cyc;
    end
    if (busy_o === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    repeat (OS) @(posedge clk);
    #1;
  endtask

  // Drives one frame and checks it against the frame-level model.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic [1:0] p,
                            input logic [1:0] s, input logic pbit, input logic [1:0] stop_lo,
                            input logic fifo_full, input string tag);
    int nb, ns, n, base, ov0, bc0, t0, exp_cyc;
    logic [8:0] mask9;
    logic [7:0] exp_data;
    logic exp_par, exp_fe;
    nb = 5 + int'(w);
    ns = (s == 2'b01) ? 2 : 1;
    n  = nb + (p[1] ? 0 : 1) + ns;
    mask9 = (9'd1 << nb) - 9'd1;
    exp_data = d & mask9[7:0];
    exp_par  = p[1] ? 1'b0 : pbit;
    exp_fe   = stop_lo[0] | ((ns == 2) & stop_lo[1]);
    // Synchronizer, START entry, half bit to centre, then one bit period per remaining bit.
    exp_cyc  = SS + 1 + OS / 2 + OS * n;

    dw = w; pm = p; sb = s; full = fifo_full;
    base = q_data.size();
    ov0  = ovr_cnt;
    bc0  = busy_cnt;
    @(posedge clk); #1;
    t0 = cyc;
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      bit_time();
    end
    if (!p[1]) begin
      rx = pbit;
      bit_time();
    end
    for (int i = 0; i < ns; i++) begin
      rx = ~stop_lo[i];
      bit_time();
    end
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    full = 1'b0;

    if (fifo_full) begin
      chk({tag, "_push_cnt"}, 32'(q_data.size() - base), 32'd0);
      chk({tag, "_ovr_cnt"}, 32'(ovr_cnt - ov0), 32'd1);
      chk({tag, "_ovr_cyc"}, 32'(ovr_cyc - t0), 32'(exp_cyc));
    end else begin
      chk({tag, "_push_cnt"}, 32'(q_data.size() - base), 32'd1);
      chk({tag, "_ovr_cnt"}, 32'(ovr_cnt - ov0), 32'd0);
      if (q_data.size() > base) begin
        chk({tag, "_data"}, 32'(q_data[base]), 32'(exp_data));
        chk({tag, "_parity"}, 32'(q_par[base]), 32'(exp_par));
        chk({tag, "_frame"}, 32'(q_fe[base]), 32'(exp_fe));
        chk({tag, "_latency"}, 32'(q_cyc[base] - t0), 32'(exp_cyc));
      end
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cnt - bc0), 32'(OS * n + 1));
    chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int base0, bc0, ov0;
    logic [7:0] rd;
    logic [1:0] rw, rp, rs, rlo;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_rx), 32'd0);
    chk("rst_write", 32'(wr), 32'd0);
    chk("rst_parity", 32'(par_o), 32'd0);
    chk("rst_frame", 32'(fe_o), 32'd0);
    chk("rst_overrun", 32'(ovr_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    send_frame(8'hA5, 2'b11, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, "a5_8n1");
    send_frame(8'h13, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, "13_5e1");
    send_frame(8'h3C, 2'b11, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0, "3c_stop_low");
    send_frame(8'h5A, 2'b10, 2'b01, 2'b01, 1'b0, 2'b10, 1'b0, "5a_7o2_stop2_low");

    // Short low glitch: must not start a frame.
    base0 = q_data.size();
    bc0   = busy_cnt;
    ov0   = ovr_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_push", 32'(q_data.size() - base0), 32'd0);
    chk("glitch_busy", 32'(busy_cnt - bc0), 32'd0);
    chk("glitch_ovr", 32'(ovr_cnt - ov0), 32'd0);

    send_frame(8'h55, 2'b11, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, "55_overrun");

    // Reset in the middle of a 0xFF data phase.
    dw = 2'b11; pm = 2'b10; sb = 2'b00;
    base0 = q_data.size();
    @(posedge clk); #1;
    rx = 1'b0;
    bit_time();
    rx = 1'b1;
    repeat (3) bit_time();
    chk("mid_frame_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_data", 32'(data_rx), 32'd0);
    chk("midrst_write", 32'(wr), 32'd0);
    chk("midrst_frame", 32'(fe_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("abort_no_push", 32'(q_data.size() - base0), 32'd0);
    send_frame(8'h81, 2'b11, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, "81_after_rst");

    // Randomized frames.
    for (int k = 0; k < 8; k++) begin
      rd  = 8'($urandom);
      rw  = 2'($urandom);
      rp  = 2'($urandom);
      rs  = 2'($urandom);
      rlo = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      send_frame(rd, rw, rp, rs, 1'($urandom), rlo, 1'b0, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
